// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Purpose  : Handshaked pipeline register built on a 2-entry skid buffer.
//            A control bundle and a data payload move between two pipeline
//            stages. Valid/ready flow control, a global stall and a
//            synchronous flush (bubble insert) are provided. in_ready_o
//            depends only on registered state, stall_i and rst_i, so the
//            ready path is cut between stages.
// Ports    : clk_i        - clock, rising edge
//            rst_i        - asynchronous active-high reset
//            stall_i      - global hold, freezes every register
//            flush_i      - synchronous flush, drops both entries
//            in_valid_i   - upstream beat present
//            in_ready_o   - stage can accept a beat
//            in_ctrl_i    - upstream control bundle  [CTRL_W]
//            in_data_i    - upstream payload         [DATA_W]
//            out_valid_o  - main entry holds a beat
//            out_ready_i  - downstream accepts
//            out_ctrl_o   - main entry control       [CTRL_W]
//            out_data_o   - main entry payload       [DATA_W]
//            bp_cnt_o     - backpressure cycle count [CNT_W]
// Options  : PIPE_SKID_STAGE_BP_CNT_EN - when defined, bp_cnt_o counts
//            unstalled, unflushed cycles with out_valid_o=1 and
//            out_ready_i=0 (saturating). When undefined, bp_cnt_o is 0.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
   parameter int DATA_W = 69,
   parameter int CTRL_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CNT_W-1:0]  bp_cnt_o
);

   // Occupancy state. The main/skid valid bits are decoded from it:
   // main valid = (state != EMPTY), skid valid = (state == FULL).
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t              r_state;
   logic [CTRL_W-1:0]   r_main_ctrl;
   logic [DATA_W-1:0]   r_main_data;
   logic [CTRL_W-1:0]   r_skid_ctrl;
   logic [DATA_W-1:0]   r_skid_data;

   logic                w_in_ready;
   logic                w_out_valid;
   logic                w_in_fire;
   logic                w_out_fire;

   // Ready never looks at out_ready_i: only registered occupancy plus the
   // global qualifiers, which keeps the upstream ready path short.
   assign w_in_ready  = ~rst_i & ~stall_i & (r_state != ST_FULL);
   assign w_out_valid = (r_state != ST_EMPTY) & ~stall_i;
   assign w_in_fire   = in_valid_i & w_in_ready;
   assign w_out_fire  = w_out_valid & out_ready_i;

   assign in_ready_o  = w_in_ready;
   assign out_valid_o = w_out_valid;
   assign out_ctrl_o  = r_main_ctrl;
   assign out_data_o  = r_main_data;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= ST_EMPTY;
         r_main_ctrl <= '0;
         r_main_data <= '0;
         r_skid_ctrl <= '0;
         r_skid_data <= '0;
      end else if (flush_i) begin
         // Bubble insert: control is zeroed so a stale beat can never
         // retire side effects; payload is left as-is.
         r_state     <= ST_EMPTY;
         r_main_ctrl <= '0;
         r_skid_ctrl <= '0;
      end else if (!stall_i) begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  r_main_ctrl <= in_ctrl_i;
                  r_main_data <= in_data_i;
                  r_state     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  r_main_ctrl <= in_ctrl_i;
                  r_main_data <= in_data_i;
               end else if (w_in_fire) begin
                  r_skid_ctrl <= in_ctrl_i;
                  r_skid_data <= in_data_i;
                  r_state     <= ST_FULL;
               end else if (w_out_fire) begin
                  r_main_ctrl <= '0;
                  r_state     <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               // Ready is low here, so only the drain side can move.
               if (w_out_fire) begin
                  r_main_ctrl <= r_skid_ctrl;
                  r_main_data <= r_skid_data;
                  r_skid_ctrl <= '0;
                  r_state     <= ST_ONE;
               end
            end
            default: begin
               r_state <= ST_EMPTY;
            end
         endcase
      end
   end

`ifdef PIPE_SKID_STAGE_BP_CNT_EN
   localparam logic [CNT_W-1:0] c_BP_MAX = '1;

   logic [CNT_W-1:0] r_bp_cnt;

   // Counts cycles where the main entry is offered but refused. Flush does
   // not clear it; only reset does.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_bp_cnt <= '0;
      end else if (!flush_i && w_out_valid && !out_ready_i && (r_bp_cnt != c_BP_MAX)) begin
         r_bp_cnt <= r_bp_cnt + 1'b1;
      end
   end

   assign bp_cnt_o = r_bp_cnt;
`else
   assign bp_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_stage
// Purpose  : Self-checking bench for pipe_skid_stage. A queue-based model of
//            the stage (FIFO of at most two beats) supplies every expected
//            value. Directed scenarios are followed by a randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

   localparam int DATA_W = 69;
   localparam int CTRL_W = 4;
   localparam int CNT_W  = 4;
`ifdef PIPE_SKID_STAGE_BP_CNT_EN
   localparam bit BP_EN = 1'b1;
`else
   localparam bit BP_EN = 1'b0;
`endif

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              stall_i;
   logic              flush_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [CTRL_W-1:0] in_ctrl_i;
   logic [DATA_W-1:0] in_data_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [CTRL_W-1:0] out_ctrl_o;
   logic [DATA_W-1:0] out_data_o;
   logic [CNT_W-1:0]  bp_cnt_o;

   pipe_skid_stage #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_ctrl_i   (in_ctrl_i),
      .in_data_i   (in_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_ctrl_o  (out_ctrl_o),
      .out_data_o  (out_data_o),
      .bp_cnt_o    (bp_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [CTRL_W-1:0] c;
      logic [DATA_W-1:0] d;
   } beat_t;

   beat_t             mq[$];      // beats held by the stage, head = output
   logic [DATA_W-1:0] m_last = '0; // payload last shown at the output
   int                m_cnt  = 0;

   function automatic logic m_ready();
      return !rst_i && !stall_i && (mq.size() < 2);
   endfunction

   function automatic logic m_valid();
      return (mq.size() > 0) && !stall_i;
   endfunction

   function automatic logic [CTRL_W-1:0] m_ctrl();
      return (mq.size() > 0) ? mq[0].c : '0;
   endfunction

   function automatic logic [DATA_W-1:0] m_data();
      return (mq.size() > 0) ? mq[0].d : m_last;
   endfunction

   function automatic logic [CNT_W-1:0] m_bp();
      return BP_EN ? CNT_W'(m_cnt) : '0;
   endfunction

   // Advance one clock: sample the inputs before the edge, then update the
   // model the way the stage should have moved. Ends 1 time unit after the
   // edge so the caller can drive new inputs away from the edge.
   task automatic step();
      logic  f_in, f_out, r, fl, st, refuse;
      beat_t b;
      r      = rst_i;
      fl     = flush_i;
      st     = stall_i;
      f_in   = in_valid_i && m_ready();
      f_out  = m_valid() && out_ready_i;
      refuse = m_valid() && !out_ready_i;
      b.c    = in_ctrl_i;
      b.d    = in_data_i;
      @(posedge clk_i);
      if (r) begin
         mq.delete();
         m_last = '0;
         m_cnt  = 0;
      end else if (fl) begin
         mq.delete();
      end else if (!st) begin
         if (refuse && m_cnt < (1 << CNT_W) - 1) m_cnt++;
         if (f_out) void'(mq.pop_front());
         if (f_in) mq.push_back(b);
         if (mq.size() > 0) m_last = mq[0].d;
      end
      #1;
   endtask

   task automatic idle_inputs();
      stall_i    = 1'b0;
      flush_i    = 1'b0;
      in_valid_i = 1'b0;
      in_ctrl_i  = '0;
      in_data_i  = '0;
      out_ready_i = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_i = 1'b1;
      idle_inputs();
      step();
      step();
      #1;
      total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL reset_valid got=%b want=0", out_valid_o); else pass_cnt++;
      total_cnt++; if (in_ready_o !== 1'b0) $display("FAIL reset_ready got=%b want=0", in_ready_o); else pass_cnt++;
      total_cnt++; if (out_ctrl_o !== '0) $display("FAIL reset_ctrl got=%h want=0", out_ctrl_o); else pass_cnt++;
      total_cnt++; if (out_data_o !== '0) $display("FAIL reset_data got=%h want=0", out_data_o); else pass_cnt++;
      total_cnt++; if (bp_cnt_o !== '0) $display("FAIL reset_bp got=%0d want=0", bp_cnt_o); else pass_cnt++;
      rst_i = 1'b0;
      #1;
      total_cnt++; if (in_ready_o !== 1'b1) $display("FAIL reset_release_ready got=%b want=1", in_ready_o); else pass_cnt++;
      step();
   endtask

   task automatic test_reset_midop();
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_ctrl_i   = 4'h3;
      in_data_i   = DATA_W'(8'h0A);
      step();
      in_data_i   = DATA_W'(8'h0B);
      step();
      in_valid_i  = 1'b0;
      #1;
      total_cnt++; if (in_ready_o !== 1'b0 || out_data_o !== DATA_W'(8'h0A)) $display("FAIL midreset_full ready=%b data=%h want ready=0 data=a", in_ready_o, out_data_o); else pass_cnt++;
      #1;
      rst_i = 1'b1;            // mid-cycle, no clock edge involved
      #1;
      total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL midreset_valid got=%b want=0", out_valid_o); else pass_cnt++;
      total_cnt++; if (out_ctrl_o !== '0) $display("FAIL midreset_ctrl got=%h want=0", out_ctrl_o); else pass_cnt++;
      total_cnt++; if (out_data_o !== '0) $display("FAIL midreset_data got=%h want=0", out_data_o); else pass_cnt++;
      total_cnt++; if (in_ready_o !== 1'b0) $display("FAIL midreset_ready got=%b want=0", in_ready_o); else pass_cnt++;
      step();
      rst_i = 1'b0;
      #1;
      total_cnt++; if (in_ready_o !== 1'b1) $display("FAIL midreset_release_ready got=%b want=1", in_ready_o); else pass_cnt++;
      step();
   endtask

   task automatic test_streaming();
      out_ready_i = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid_i = 1'b1;
         in_ctrl_i  = 4'b1001;
         in_data_i  = DATA_W'(i);
         #1;
         total_cnt++; if (in_ready_o !== 1'b1) $display("FAIL stream_ready beat=%0d got=%b want=1", i, in_ready_o); else pass_cnt++;
         if (i > 1) begin
            total_cnt++;
            if (out_valid_o !== 1'b1 || out_data_o !== DATA_W'(i - 1) || out_ctrl_o !== 4'b1001)
               $display("FAIL stream_out beat=%0d got v=%b c=%h d=%h want v=1 c=9 d=%0d", i - 1, out_valid_o, out_ctrl_o, out_data_o, i - 1);
            else pass_cnt++;
         end
         step();
      end
      in_valid_i = 1'b0;
      #1;
      total_cnt++; if (out_valid_o !== 1'b1 || out_data_o !== DATA_W'(8)) $display("FAIL stream_last got v=%b d=%h want v=1 d=8", out_valid_o, out_data_o); else pass_cnt++;
      step();
      total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL stream_drain got=%b want=0", out_valid_o); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int n;
      n = 0;
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_ctrl_i   = 4'h5;
      in_data_i   = DATA_W'(8'h11);
      #1;
      total_cnt++; if (in_ready_o !== 1'b1) $display("FAIL bp_accept1 got=%b want=1", in_ready_o); else pass_cnt++;
      step();
      in_data_i = DATA_W'(8'h22);
      #1;
      total_cnt++; if (in_ready_o !== 1'b1) $display("FAIL bp_accept2 got=%b want=1", in_ready_o); else pass_cnt++;
      step(); n++;
      in_data_i = DATA_W'(8'h33);
      for (int k = 0; k < 3; k++) begin
         #1;
         total_cnt++; if (in_ready_o !== 1'b0) $display("FAIL bp_full_ready cyc=%0d got=%b want=0", k, in_ready_o); else pass_cnt++;
         step(); n++;
      end
      total_cnt++; if (bp_cnt_o !== (BP_EN ? CNT_W'(n) : '0)) $display("FAIL bp_count got=%0d want=%0d", bp_cnt_o, BP_EN ? n : 0); else pass_cnt++;
      out_ready_i = 1'b1;
      #1;
      total_cnt++; if (out_valid_o !== 1'b1 || out_data_o !== DATA_W'(8'h11)) $display("FAIL bp_out1 got v=%b d=%h want 11", out_valid_o, out_data_o); else pass_cnt++;
      step();
      total_cnt++; if (out_valid_o !== 1'b1 || out_data_o !== DATA_W'(8'h22) || in_ready_o !== 1'b1) $display("FAIL bp_out2 got v=%b d=%h r=%b want 22 r=1", out_valid_o, out_data_o, in_ready_o); else pass_cnt++;
      step();
      in_valid_i = 1'b0;
      #1;
      total_cnt++; if (out_valid_o !== 1'b1 || out_data_o !== DATA_W'(8'h33)) $display("FAIL bp_out3 got v=%b d=%h want 33", out_valid_o, out_data_o); else pass_cnt++;
      step();
      total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL bp_drained got=%b want=0", out_valid_o); else pass_cnt++;
   endtask

   task automatic test_stall();
      int seen;
      seen = 0;
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_ctrl_i   = 4'h2;
      in_data_i   = DATA_W'(8'h55);
      step();
      in_valid_i  = 1'b0;
      stall_i     = 1'b1;
      out_ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         total_cnt++;
         if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0 || out_data_o !== DATA_W'(8'h55))
            $display("FAIL stall_hold cyc=%0d got v=%b r=%b d=%h want v=0 r=0 d=55", k, out_valid_o, in_ready_o, out_data_o);
         else pass_cnt++;
         step();
      end
      stall_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         if (out_valid_o === 1'b1 && out_data_o === DATA_W'(8'h55)) seen++;
         step();
      end
      total_cnt++; if (seen != 1) $display("FAIL stall_deliver_once got=%0d want=1", seen); else pass_cnt++;
   endtask

   task automatic test_flush_priority();
      logic [DATA_W-1:0] held;
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_ctrl_i   = 4'hF;
      in_data_i   = DATA_W'(8'h66);
      step();
      in_data_i   = DATA_W'(8'h77);
      step();
      held = out_data_o;
      flush_i    = 1'b1;
      stall_i    = 1'b1;
      in_data_i  = DATA_W'(8'h88);
      step();
      flush_i     = 1'b0;
      stall_i     = 1'b0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      #1;
      total_cnt++; if (out_valid_o !== 1'b0 || out_ctrl_o !== '0) $display("FAIL flush_out got v=%b c=%h want v=0 c=0", out_valid_o, out_ctrl_o); else pass_cnt++;
      total_cnt++; if (in_ready_o !== 1'b1) $display("FAIL flush_empty_ready got=%b want=1", in_ready_o); else pass_cnt++;
      total_cnt++; if (out_data_o !== DATA_W'(8'h66) || held !== DATA_W'(8'h66)) $display("FAIL flush_data_kept got=%h want=66", out_data_o); else pass_cnt++;
      step();
      total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL flush_no_beat got=%b want=0", out_valid_o); else pass_cnt++;
   endtask

   task automatic test_saturation();
      rst_i = 1'b1;
      idle_inputs();
      step();
      rst_i = 1'b0;
      in_valid_i = 1'b1;
      in_data_i  = DATA_W'(8'h99);
      step();
      in_valid_i = 1'b0;
      for (int k = 0; k < 20; k++) step();
      total_cnt++; if (bp_cnt_o !== (BP_EN ? 4'd15 : 4'd0)) $display("FAIL sat_value got=%0d want=%0d", bp_cnt_o, BP_EN ? 15 : 0); else pass_cnt++;
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      step();
      total_cnt++; if (bp_cnt_o !== (BP_EN ? 4'd15 : 4'd0)) $display("FAIL sat_hold got=%0d want=%0d", bp_cnt_o, BP_EN ? 15 : 0); else pass_cnt++;
      // Clear the counter again so the random run starts from a known point.
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      step();
   endtask

   task automatic test_random();
      logic [95:0] r;
      for (int k = 0; k < 400; k++) begin
         r           = {$urandom(), $urandom(), $urandom()};
         in_valid_i  = ($urandom_range(0, 3) != 0);
         out_ready_i = ($urandom_range(0, 2) != 0);
         stall_i     = ($urandom_range(0, 9) == 0);
         flush_i     = ($urandom_range(0, 19) == 0);
         in_ctrl_i   = CTRL_W'($urandom());
         in_data_i   = r[DATA_W-1:0];
         #1;
         total_cnt++; if (in_ready_o !== m_ready()) $display("FAIL rnd_ready cyc=%0d got=%b want=%b", k, in_ready_o, m_ready()); else pass_cnt++;
         total_cnt++; if (out_valid_o !== m_valid()) $display("FAIL rnd_valid cyc=%0d got=%b want=%b", k, out_valid_o, m_valid()); else pass_cnt++;
         total_cnt++; if (out_ctrl_o !== m_ctrl()) $display("FAIL rnd_ctrl cyc=%0d got=%h want=%h", k, out_ctrl_o, m_ctrl()); else pass_cnt++;
         total_cnt++; if (out_data_o !== m_data()) $display("FAIL rnd_data cyc=%0d got=%h want=%h", k, out_data_o, m_data()); else pass_cnt++;
         total_cnt++; if (bp_cnt_o !== m_bp()) $display("FAIL rnd_bp cyc=%0d got=%0d want=%0d", k, bp_cnt_o, m_bp()); else pass_cnt++;
         step();
      end
   endtask

   initial begin
      test_reset();
      test_reset_midop();
      test_streaming();
      test_backpressure();
      test_stall();
      test_flush_priority();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised, handshaked successor to the fixed EX/MEM-style pipeline register.
- Carries a CTRL_W control bundle and a DATA_W payload between two pipeline stages.
- Uses a 2-entry skid buffer with valid/ready flow control, a global stall and a synchronous flush (bubble insert).
- in_ready_o is derived from registered state only, so it breaks the ready timing path between stages.

Parameters:
- DATA_W, 69: payload width (e.g. ALU result 32 + RS2 data 32 + RD address 5).
- CTRL_W, 4: control bundle width (RegWrite, MemtoReg, MemRead, MemWrite); cleared on flush/reset.
- CNT_W, 16: width of the backpressure counter (optional feature).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- stall_i  input  1  global hold; freezes all state.
- flush_i  input  1  synchronous flush; drops both entries.
- in_valid_i  input  1  upstream has a beat.
- in_ready_o  output  1  stage can accept a beat.
- in_ctrl_i  input  CTRL_W  upstream control bundle.
- in_data_i  input  DATA_W  upstream payload.
- out_valid_o  output  1  main entry holds a beat.
- out_ready_i  input  1  downstream accepts.
- out_ctrl_o  output  CTRL_W  main entry control.
- out_data_o  output  DATA_W  main entry payload.
- bp_cnt_o  output  CNT_W  backpressure cycle count (optional feature).

Behaviour:
- Storage: main entry (drives outputs) and skid entry; each holds valid, ctrl and data.
- State: EMPTY (neither valid), ONE (main valid only), FULL (both valid).
- Reset (async): state EMPTY; all valids 0; ctrl and data for both entries 0; bp_cnt_o 0.
- in_ready_o = ~rst_i & ~stall_i & (state != FULL). It is 0 while rst_i is high.
- out_valid_o = main_valid & ~stall_i. out_ctrl_o and out_data_o stay stable during a stall.
- in_fire = in_valid_i & in_ready_o.
- out_fire = out_valid_o & out_ready_i.
- Latency: a beat accepted at edge N appears on the outputs after edge N (1 cycle). There is no combinational path from in_* to out_*.
- Edge priority:
  - rst_i, then flush_i, then stall_i, then normal.
  - Flush: state goes to EMPTY, both valids 0, both ctrl 0, data unchanged. Flush overrides stall and discards a simultaneous in_fire.
  - Stall (no flush): every register holds, including bp_cnt_o.
- Transitions (no flush, no stall):
  - EMPTY: in_fire loads main, go to ONE; otherwise stay.
  - ONE with in_fire and out_fire: main loads input, stay in ONE.
  - ONE with in_fire only: skid loads input, go to FULL.
  - ONE with out_fire only: go to EMPTY, main valid 0, main ctrl 0.
  - ONE with neither: hold.
  - FULL with out_fire: main loads skid, skid valid 0, skid ctrl 0, go to ONE. in_fire is impossible because ready is 0.
  - FULL without out_fire: hold.
- Ordering: strict FIFO. No beat is duplicated or dropped except by flush.
- Sustained throughput: 1 beat per cycle while out_ready_i stays 1.

Optional Feature:
- Macro PIPE_SKID_STAGE_BP_CNT_EN.
- Defined: bp_cnt_o increments by 1 every unstalled, unflushed cycle with out_valid_o=1 and out_ready_i=0. It saturates at 2^CNT_W-1, resets to 0 only on rst_i, and is not cleared by flush.
- Undefined: no counter logic; bp_cnt_o is tied to 0.

Test Plan:
- Reset mid-operation: state FULL with beats 0xA, 0xB; assert rst_i asynchronously. Require that out_valid_o=0, out_ctrl_o=0, out_data_o=0 and in_ready_o=0 immediately, without waiting for a clock edge; after release, in_ready_o=1.
- Streaming: out_ready_i=1, push data 1..8 back-to-back with ctrl 4'b1001. Require that out_data_o shows 1..8 on consecutive cycles, 1 cycle after each input, and in_ready_o never drops.
- Backpressure/skid:
  - Push 0x11, 0x22, 0x33 with out_ready_i=0. Require that 0x11 and 0x22 are accepted, in_ready_o=0 after the second accept, and 0x33 is held upstream.
  - Then raise out_ready_i. Require that the outputs show 0x11, 0x22, 0x33 in order.
  - With PIPE_SKID_STAGE_BP_CNT_EN defined, bp_cnt_o equals the number of stalled-valid cycles.
- Stall: state ONE with 0x55, assert stall_i for 3 cycles with out_ready_i=1. Require that out_valid_o=0, in_ready_o=0 and out_data_o stays 0x55; after release, 0x55 is delivered exactly once.
- Flush priority: state FULL, assert flush_i, stall_i and in_valid_i together. Next cycle require out_valid_o=0, out_ctrl_o=0, state EMPTY, and no beat delivered.
- Saturation (macro defined, CNT_W=4): hold backpressure for 20 cycles. Require that bp_cnt_o=15 and stays 15.
